// File: rtl/kamikaze_fetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : kamikaze_fetch_if
//  Purpose  : Instruction memory port between kamikaze_fetch and the memory.
//             One read request at a time: req/addr held until gnt, data
//             returned in order on rvalid at least one cycle after gnt.
//  Signals  : imem_req_o    - read request (fetch -> memory)
//             imem_addr_o   - word address, bits [1:0] = 0 (fetch -> memory)
//             imem_gnt_i    - request accepted this cycle (memory -> fetch)
//             imem_rvalid_i - read data valid (memory -> fetch)
//             imem_rdata_i  - read data, little-endian (memory -> fetch)
//  Modports : master (fetch unit), slave (memory)
//  Revision : 1.0 - initial release
// ============================================================================
interface kamikaze_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/kamikaze_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : kamikaze_fetch
//  Purpose  : Instruction fetch unit feeding kamikaze_decode. Issues word
//             reads to the instruction memory, realigns 16/32-bit parcels
//             through a halfword holding buffer and presents one registered
//             instruction per valid cycle, with stall and redirect.
//  Params   : RESET_PC - first fetch PC after reset
//  Macros   : KAMIKAZE_RVC_EN - defined: compressed (16-bit) parcel support.
//             Undefined: every parcel is 32-bit, PC advances by 4,
//             redirect_pc_i[1:0] ignored, is_compressed_instr_o tied to 0.
//  Ports    : clk_i, rst_i            - clock, synchronous active-high reset
//             imem (master)           - instruction memory read port
//             stall_i                 - decode cannot accept; outputs hold
//             redirect_i/redirect_pc_i- flush and restart fetch at new PC
//             instr_o                 - raw instruction (16-bit zero-extended)
//             instr_valid_o           - instr_o/pc_o valid
//             pc_o                    - address of instr_o
//             is_compressed_instr_o   - instr_o[1:0] != 2'b11
//  Revision : 1.0 - initial release
// ============================================================================
module kamikaze_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    kamikaze_fetch_if.master imem,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    output logic [31:0]      pc_o,
    output logic             is_compressed_instr_o
);

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_REQ   = 2'd1,
        c_WAIT  = 2'd2,
        c_FLUSH = 2'd3
    } state_t;

    localparam logic [31:0] c_RESET_FPC = {RESET_PC[31:2], 2'b00};
`ifdef KAMIKAZE_RVC_EN
    localparam logic [31:0] c_RESET_PC  = {RESET_PC[31:1], 1'b0};
`else
    localparam logic [31:0] c_RESET_PC  = c_RESET_FPC;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fpc;
    logic [31:0] r_pc;
    logic [31:0] r_rbuf;
    logic        r_rbuf_v;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_pc_out;

    logic        w_req;
    logic        w_gnt;
    logic        w_resp;
    logic        w_word_v;
    logic [31:0] w_word;
    logic        w_can_emit;
    logic        w_emit;
    logic [31:0] w_emit_instr;
    logic        w_consume;
    logic [31:0] w_pc_inc;
    logic [31:0] w_redirect_pc;
    logic        w_unused;

`ifdef KAMIKAZE_RVC_EN
    logic [15:0] r_hold;
    logic        r_hold_v;
    logic        r_is_c;
    logic [15:0] w_hold_nxt;
    logic        w_hold_v_nxt;
    logic        w_emit_c;

    assign w_redirect_pc         = {redirect_pc_i[31:1], 1'b0};
    assign is_compressed_instr_o = r_is_c;
`else
    assign w_redirect_pc         = {redirect_pc_i[31:2], 2'b00};
    assign is_compressed_instr_o = 1'b0;
`endif
    assign w_unused = ^redirect_pc_i[1:0];

    // A new word is requested whenever the response buffer is empty; the
    // buffer only fills from a response, so req stays high until granted.
    assign w_req  = (r_state == c_REQ) && !r_rbuf_v;
    assign w_gnt  = w_req && imem.imem_gnt_i;
    // Responses are only accepted for our own granted request; stale data
    // seen in REQ (after reset) or in FLUSH is ignored.
    assign w_resp = (r_state == c_WAIT) && imem.imem_rvalid_i;

    // The response is forwarded straight into the emit logic in its arrival
    // cycle; it only lands in rbuf when not consumed. rbuf_v and w_resp are
    // mutually exclusive because no request is made while rbuf is full.
    assign w_word_v = r_rbuf_v || w_resp;
    assign w_word   = r_rbuf_v ? r_rbuf : imem.imem_rdata_i;

    assign w_can_emit = !r_instr_valid || !stall_i;

    assign imem.imem_req_o  = w_req;
    assign imem.imem_addr_o = r_fpc;

    assign instr_o       = r_instr;
    assign instr_valid_o = r_instr_valid;
    assign pc_o          = r_pc_out;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  w_state_nxt = c_REQ;
            c_REQ:   if (w_gnt) w_state_nxt = c_WAIT;
            c_WAIT:  if (imem.imem_rvalid_i) w_state_nxt = c_REQ;
            c_FLUSH: if (imem.imem_rvalid_i) w_state_nxt = c_REQ;
            default: w_state_nxt = c_IDLE;
        endcase
        if (redirect_i) begin
            // A request granted now, or still unanswered, must have its
            // response swallowed. A response arriving in the redirect cycle
            // is simply dropped, so no flush is needed then.
            if (w_gnt ||
                ((r_state == c_WAIT || r_state == c_FLUSH) && !imem.imem_rvalid_i)) begin
                w_state_nxt = c_FLUSH;
            end else begin
                w_state_nxt = c_REQ;
            end
        end
    end

    // ------------------------------------------------------------------
    // Parcel realignment / emit decision
    // ------------------------------------------------------------------
    always_comb begin
        w_emit       = 1'b0;
        w_emit_instr = '0;
        w_consume    = 1'b0;
        w_pc_inc     = '0;
`ifdef KAMIKAZE_RVC_EN
        w_emit_c     = 1'b0;
        w_hold_nxt   = r_hold;
        w_hold_v_nxt = r_hold_v;
        if (w_can_emit) begin
            if (r_hold_v) begin
                if (r_hold[1:0] != 2'b11) begin
                    // Held halfword is a full compressed instruction.
                    w_emit       = 1'b1;
                    w_emit_c     = 1'b1;
                    w_emit_instr = {16'h0000, r_hold};
                    w_pc_inc     = 32'd2;
                    w_hold_v_nxt = 1'b0;
                end else if (w_word_v) begin
                    // 32-bit parcel straddling the word boundary.
                    w_emit       = 1'b1;
                    w_emit_instr = {w_word[15:0], r_hold};
                    w_pc_inc     = 32'd4;
                    w_hold_nxt   = w_word[31:16];
                    w_consume    = 1'b1;
                end
            end else if (w_word_v) begin
                w_consume = 1'b1;
                if (!r_pc[1]) begin
                    if (w_word[1:0] != 2'b11) begin
                        w_emit       = 1'b1;
                        w_emit_c     = 1'b1;
                        w_emit_instr = {16'h0000, w_word[15:0]};
                        w_pc_inc     = 32'd2;
                        w_hold_nxt   = w_word[31:16];
                        w_hold_v_nxt = 1'b1;
                    end else begin
                        w_emit       = 1'b1;
                        w_emit_instr = w_word;
                        w_pc_inc     = 32'd4;
                    end
                end else begin
                    if (w_word[17:16] != 2'b11) begin
                        w_emit       = 1'b1;
                        w_emit_c     = 1'b1;
                        w_emit_instr = {16'h0000, w_word[31:16]};
                        w_pc_inc     = 32'd2;
                    end else begin
                        // Halfword target starts a 32-bit parcel: park the
                        // low half and wait for the next word.
                        w_hold_nxt   = w_word[31:16];
                        w_hold_v_nxt = 1'b1;
                    end
                end
            end
        end
`else
        if (w_can_emit && w_word_v) begin
            w_emit       = 1'b1;
            w_emit_instr = w_word;
            w_pc_inc     = 32'd4;
            w_consume    = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fpc         <= c_RESET_FPC;
            r_pc          <= c_RESET_PC;
            r_rbuf        <= '0;
            r_rbuf_v      <= 1'b0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pc_out      <= RESET_PC;
`ifdef KAMIKAZE_RVC_EN
            r_hold        <= '0;
            r_hold_v      <= 1'b0;
            r_is_c        <= 1'b0;
`endif
        end else if (redirect_i) begin
            r_fpc         <= {w_redirect_pc[31:2], 2'b00};
            r_pc          <= w_redirect_pc;
            r_rbuf_v      <= 1'b0;
            r_instr_valid <= 1'b0;
`ifdef KAMIKAZE_RVC_EN
            r_hold_v      <= 1'b0;
`endif
        end else begin
            if (w_gnt) begin
                r_fpc <= r_fpc + 32'd4;
            end
            if (r_rbuf_v && w_consume) begin
                r_rbuf_v <= 1'b0;
            end else if (w_resp && !w_consume) begin
                r_rbuf   <= imem.imem_rdata_i;
                r_rbuf_v <= 1'b1;
            end
            r_pc <= r_pc + w_pc_inc;
`ifdef KAMIKAZE_RVC_EN
            r_hold   <= w_hold_nxt;
            r_hold_v <= w_hold_v_nxt;
`endif
            if (w_can_emit) begin
                r_instr_valid <= w_emit;
                if (w_emit) begin
                    r_instr  <= w_emit_instr;
                    r_pc_out <= r_pc;
`ifdef KAMIKAZE_RVC_EN
                    r_is_c   <= w_emit_c;
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire
